// File: rtl/cpsr_unit.sv
// Flag generation and architectural status register with single-level exception save/restore.
// Drives {V,N,C,Z} to the condition stage, plus a same-cycle bypass of the next flag value.
module cpsr_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       opin,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [WIDTH-1:0] resin,
    input  logic             shiftcarryin,
    input  logic             setflagsin,
    input  logic             writein,
    input  logic [3:0]       writedatain,
    input  logic             excentryin,
    input  logic             excretin,
    output logic [3:0]       cpsrout,
    output logic [3:0]       cpsrnextout,
    output logic [3:0]       spsrout,
    output logic             inexcout,
    output logic             errout
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXC  = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [3:0]     cpsr_q, cpsr_d;
    logic [3:0]     spsr_q, spsr_d;
    logic           err_q, err_d;

    logic [WIDTH:0] add_sum;
    logic [3:0]     flags_alu;
    logic [3:0]     flags_upd;
    logic           f_n, f_z, f_c, f_v;

    assign add_sum = {1'b0, ain} + {1'b0, bin};

    // Computed flags; C and V fall back to the held register value when the class does not define them.
    always_comb begin
        f_n = resin[MSB];
        f_z = (resin == '0);
        f_c = cpsr_q[1];
        f_v = cpsr_q[3];
        unique case (opin)
            OP_LOGIC: f_c = shiftcarryin;
            OP_ADD: begin
                f_c = add_sum[WIDTH];
                f_v = (ain[MSB] == bin[MSB]) && (resin[MSB] != ain[MSB]);
            end
            OP_SUB: begin
                f_c = (ain >= bin);
                f_v = (ain[MSB] != bin[MSB]) && (resin[MSB] != ain[MSB]);
            end
            default: ;
        endcase
        flags_alu = {f_v, f_n, f_c, f_z};
    end

    assign flags_upd = writein ? writedatain : (setflagsin ? flags_alu : cpsr_q);

    // Next-state: exception return owns cpsr in EXC; otherwise write beats setflags.
    always_comb begin
        state_d = state_q;
        cpsr_d  = cpsr_q;
        spsr_d  = spsr_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                cpsr_d = flags_upd;
                if (excretin) begin
                    err_d = 1'b1;
                end else if (excentryin) begin
                    spsr_d  = cpsr_q;
                    state_d = ST_EXC;
                end
            end
            ST_EXC: begin
                if (excretin) begin
                    cpsr_d = spsr_q;
                    if (!excentryin) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cpsr_d = flags_upd;
                    if (excentryin) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cpsr_q  <= 4'b0000;
            spsr_q  <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cpsr_q  <= cpsr_d;
            spsr_q  <= spsr_d;
            err_q   <= err_d;
        end
    end

    assign cpsrout     = cpsr_q;
    assign cpsrnextout = cpsr_d;
    assign spsrout     = spsr_q;
    assign inexcout    = (state_q == ST_EXC);
    assign errout      = err_q;

endmodule

// File: tb/tb_cpsr_unit.sv
// Self-checking bench for cpsr_unit: directed scenarios plus randomized traffic against a flag model.
module tb_cpsr_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  opin;
    logic [31:0] ain, bin, resin;
    logic        shiftcarryin, setflagsin, writein, excentryin, excretin;
    logic [3:0]  writedatain;
    logic [3:0]  cpsrout, cpsrnextout, spsrout;
    logic        inexcout, errout;

    int checks = 0;
    int failures = 0;

    cpsr_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opin(opin), .ain(ain), .bin(bin), .resin(resin),
        .shiftcarryin(shiftcarryin), .setflagsin(setflagsin), .writein(writein),
        .writedatain(writedatain), .excentryin(excentryin), .excretin(excretin),
        .cpsrout(cpsrout), .cpsrnextout(cpsrnextout), .spsrout(spsrout),
        .inexcout(inexcout), .errout(errout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic sc, input logic sf, input logic wr,
                         input logic [3:0] wd, input logic en, input logic ret);
        opin = op; ain = a; bin = b; resin = r; shiftcarryin = sc;
        setflagsin = sf; writein = wr; writedatain = wd; excentryin = en; excretin = ret;
    endtask

    task automatic idle();
        drive(2'b00, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic write_flags(input logic [3:0] v);
        drive(2'b00, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
        tick();
    endtask

    // Spec-level flag model using wide integer arithmetic.
    function automatic logic [3:0] model_flags(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] r,
                                               input logic sc, input logic [3:0] prev);
        longint ua, ub, sa, sb, s;
        logic n, z, c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = r[31];
        z = (r == 32'd0);
        c = prev[1];
        v = prev[3];
        case (op)
            2'b00: c = sc;
            2'b01: begin
                c = (ua + ub) > 64'sh0FFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10: begin
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: ;
        endcase
        return {v, n, c, z};
    endfunction

    task automatic test_reset();
        write_flags(4'b1010);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpsrout, spsrout, inexcout, errout} !== 10'd0) begin
            failures++;
            $display("FAIL reset_async: got cpsr=%b spsr=%b inexc=%b err=%b, want all zero",
                     cpsrout, spsrout, inexcout, errout);
        end
        checks++;
        if (cpsrnextout !== 4'b0000) begin
            failures++;
            $display("FAIL reset_next: got %b want 0000", cpsrnextout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        drive(2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (cpsrnextout !== 4'b0011) begin
            failures++;
            $display("FAIL sub_bypass: got %b want 0011", cpsrnextout);
        end
        tick();
        checks++;
        if (cpsrout !== 4'b0011) begin
            failures++;
            $display("FAIL sub_equal: got %b want 0011", cpsrout);
        end
    endtask

    task automatic test_add();
        drive(2'b01, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b1100) begin
            failures++;
            $display("FAIL add_overflow: got %b want 1100", cpsrout);
        end
        drive(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b0011) begin
            failures++;
            $display("FAIL add_carry_wrap: got %b want 0011", cpsrout);
        end
        drive(2'b10, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b0100) begin
            failures++;
            $display("FAIL sub_borrow: got %b want 0100", cpsrout);
        end
    endtask

    task automatic test_logical();
        write_flags(4'b1000);
        drive(2'b00, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b1110) begin
            failures++;
            $display("FAIL logical_flags: got %b want 1110", cpsrout);
        end
        write_flags(4'b1000);
        drive(2'b00, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b1000) begin
            failures++;
            $display("FAIL logical_hold: got %b want 1000", cpsrout);
        end
    endtask

    task automatic test_write_move();
        drive(2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b0101) begin
            failures++;
            $display("FAIL write_priority: got %b want 0101", cpsrout);
        end
        write_flags(4'b1010);
        drive(2'b11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (cpsrout !== 4'b1011) begin
            failures++;
            $display("FAIL move_flags: got %b want 1011", cpsrout);
        end
    endtask

    task automatic test_exc_flow();
        write_flags(4'b0011);
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if (spsrout !== 4'b0011 || inexcout !== 1'b1) begin
            failures++;
            $display("FAIL exc_entry: got spsr=%b inexc=%b want 0011/1", spsrout, inexcout);
        end
        write_flags(4'b1100);
        checks++;
        if (cpsrout !== 4'b1100) begin
            failures++;
            $display("FAIL exc_write: got %b want 1100", cpsrout);
        end
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if (cpsrout !== 4'b0011 || inexcout !== 1'b0 || errout !== 1'b0) begin
            failures++;
            $display("FAIL exc_return: got cpsr=%b inexc=%b err=%b want 0011/0/0",
                     cpsrout, inexcout, errout);
        end
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick();
        checks++;
        if (cpsrout !== 4'b0011 || errout !== 1'b1 || inexcout !== 1'b0) begin
            failures++;
            $display("FAIL ret_in_idle: got cpsr=%b err=%b inexc=%b want 0011/1/0",
                     cpsrout, errout, inexcout);
        end
    endtask

    task automatic test_tail_chain();
        apply_reset();
        write_flags(4'b0011);
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        write_flags(4'b1100);
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        #1;
        checks++;
        if (cpsrnextout !== 4'b0011) begin
            failures++;
            $display("FAIL tail_bypass: got %b want 0011", cpsrnextout);
        end
        tick();
        checks++;
        if (cpsrout !== 4'b0011 || spsrout !== 4'b0011 || inexcout !== 1'b1 || errout !== 1'b0) begin
            failures++;
            $display("FAIL tail_chain: got cpsr=%b spsr=%b inexc=%b err=%b want 0011/0011/1/0",
                     cpsrout, spsrout, inexcout, errout);
        end
        drive(2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        tick();
        checks++;
        if (errout !== 1'b1 || spsrout !== 4'b0011 || inexcout !== 1'b1) begin
            failures++;
            $display("FAIL nested_entry: got err=%b spsr=%b inexc=%b want 1/0011/1",
                     errout, spsrout, inexcout);
        end
    endtask

    task automatic test_random();
        logic [3:0] m_cpsr, m_spsr, comp, upd, nxt;
        logic       m_exc, m_err;
        logic [1:0] op;
        logic [31:0] a, b, r;
        logic sc, sf, wr, en, ret;
        logic [3:0] wd;
        apply_reset();
        m_cpsr = 4'd0; m_spsr = 4'd0; m_exc = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom();
            sc = 1'($urandom_range(0, 1));
            sf = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 4) == 0);
            wd = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 6) == 0);
            ret = ($urandom_range(0, 6) == 0);
            case (op)
                2'b01:   r = a + b;
                2'b10:   r = a - b;
                default: r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            endcase
            if (!m_exc && ret) begin
                en = 1'b0; wr = 1'b0; sf = 1'b0;
            end
            comp = model_flags(op, a, b, r, sc, m_cpsr);
            upd  = wr ? wd : (sf ? comp : m_cpsr);
            nxt  = (m_exc && ret) ? m_spsr : upd;
            drive(op, a, b, r, sc, sf, wr, wd, en, ret);
            #1;
            checks++;
            if (cpsrnextout !== nxt) begin
                failures++;
                $display("FAIL rand_next[%0d]: got %b want %b", i, cpsrnextout, nxt);
            end
            if (m_exc) begin
                if (ret) m_exc = en;
                else if (en) m_err = 1'b1;
            end else begin
                if (ret) m_err = 1'b1;
                else if (en) begin
                    m_spsr = m_cpsr;
                    m_exc  = 1'b1;
                end
            end
            m_cpsr = nxt;
            tick();
            checks++;
            if (cpsrout !== m_cpsr || spsrout !== m_spsr || inexcout !== m_exc || errout !== m_err) begin
                failures++;
                $display("FAIL rand_state[%0d]: got cpsr=%b spsr=%b inexc=%b err=%b want %b/%b/%b/%b",
                         i, cpsrout, spsrout, inexcout, errout, m_cpsr, m_spsr, m_exc, m_err);
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({cpsrout, spsrout, inexcout, errout} !== 10'd0) begin
            failures++;
            $display("FAIL initial_reset: got cpsr=%b spsr=%b inexc=%b err=%b", cpsrout, spsrout,
                     inexcout, errout);
        end
        test_reset();
        test_add();
        test_logical();
        test_write_move();
        test_exc_flow();
        test_tail_chain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
